// File: rtl/sw_segment_scheduler_pkg.sv
// Shared definitions for the Smith-Waterman segment scheduler.
//   - default geometry (PE count, T depth, score width)
//   - scheduler state encoding
//   - boundary entry layout {v, f} as carried between passes
package sw_segment_scheduler_pkg;

  localparam int VW_DEF      = 16;
  localparam int PE_SIZE_DEF = 64;
  localparam int MAX_T_DEF   = 1024;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_RUN    = 2'd2,
    ST_DONE   = 2'd3
  } sched_state_e;

  // One boundary-column entry for the default score width. The buffer
  // stores it as {v, f}, V in the upper half.
  typedef struct packed {
    logic [VW_DEF-1:0] v;
    logic [VW_DEF-1:0] f;
  } bnd_entry_t;

endpackage

// File: rtl/sw_bound_buf.sv
// Boundary-column buffer: simple dual-port DEPTH x DW RAM.
//   clk, rst          : clock, synchronous active-high reset (read register only)
//   wr_en/addr/data   : write port
//   rd_en/addr        : synchronous read, data in rd_data one cycle later
//   rd_clr            : forces the read register to zero instead of reading
//   rd_data           : registered read data
// A read and a write to the same address in one cycle return the old
// contents. The array itself is never reset.
module sw_bound_buf
  import sw_segment_scheduler_pkg::*;
#(
  parameter int DEPTH = MAX_T_DEF,
  parameter int AW    = $clog2(MAX_T_DEF),
  parameter int DW    = 2 * VW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic          rd_clr,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem_r [DEPTH];
  logic [DW-1:0] rd_data_r;

  // Write port; no reset so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // Read port; the non-blocking write above makes collisions read old data.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_r <= {DW{1'b0}};
    end else if (rd_en && rd_clr) begin
      rd_data_r <= {DW{1'b0}};
    end else if (rd_en) begin
      rd_data_r <= mem_r[rd_addr];
    end
  end

  assign rd_data = rd_data_r;

endmodule

// File: rtl/sw_segment_scheduler.sv
// Multi-pass Smith-Waterman sequencer. Splits the query S into PE_SIZE
// segments, launches one array pass per segment, carries the last-PE
// boundary column (V, F per T position) to the next pass through
// sw_bound_buf, and folds each pass's max score into a global result.
// Ports:
//   clk, rst                       : clock, synchronous active-high reset
//   i_start, i_s_len, i_t_size     : alignment request and lengths
//   o_busy                         : accepted start until o_valid
//   o_seg_start/base/len/first     : per-segment launch to the array controller
//   i_seg_valid, i_seg_result      : pass completion and its max V
//   i_bnd_wr, i_bnd_v, i_bnd_f     : last-PE boundary output
//   i_bnd_rd, o_bnd_v, o_bnd_f     : boundary feed for PE 0 (one-cycle latency)
//   o_result, o_valid              : global max score, one-cycle done pulse
// Optional: define SW_SEG_SCHED_PERF_EN to add o_cycles, a saturating
// count of busy cycles for the current/last alignment.
module sw_segment_scheduler
  import sw_segment_scheduler_pkg::*;
#(
  parameter  int PE_SIZE = PE_SIZE_DEF,
  parameter  int MAX_T   = MAX_T_DEF,
  parameter  int VW      = VW_DEF,
  localparam int TW      = $clog2(MAX_T) + 1,
  localparam int AW      = $clog2(MAX_T),
  localparam int SLW     = $clog2(PE_SIZE) + 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_start,
  input  logic [15:0]    i_s_len,
  input  logic [TW-1:0]  i_t_size,
  output logic           o_busy,
  output logic           o_seg_start,
  output logic [15:0]    o_seg_base,
  output logic [SLW-1:0] o_seg_len,
  output logic           o_seg_first,
  input  logic           i_seg_valid,
  input  logic [VW-1:0]  i_seg_result,
  input  logic           i_bnd_wr,
  input  logic [VW-1:0]  i_bnd_v,
  input  logic [VW-1:0]  i_bnd_f,
  input  logic           i_bnd_rd,
  output logic [VW-1:0]  o_bnd_v,
  output logic [VW-1:0]  o_bnd_f,
  output logic [VW-1:0]  o_result,
`ifdef SW_SEG_SCHED_PERF_EN
  output logic [31:0]    o_cycles,
`endif
  output logic           o_valid
);

  sched_state_e   state_r, state_s;
  logic [15:0]    s_len_r;
  logic [TW-1:0]  t_size_r;
  logic [15:0]    seg_base_r;
  logic [SLW-1:0] seg_len_r;
  logic           seg_first_r;
  logic [VW-1:0]  max_r, max_s;
  logic [VW-1:0]  result_r;
  logic           busy_r, seg_start_r, valid_r;
  logic [TW-1:0]  rd_ptr_r, wr_ptr_r;

  logic           accept_s, seg_done_s;
  logic [15:0]    seg_next_s;
  logic [16:0]    seg_end_s;
  logic           rd_en_s, rd_clr_s, wr_en_s;
  logic [2*VW-1:0] rd_data_s;

  // Characters left for the segment starting at base_v, capped at PE_SIZE.
  function automatic logic [SLW-1:0] seg_len_f(input logic [15:0] len_v,
                                               input logic [15:0] base_v);
    logic [15:0] rem_v;
    rem_v = len_v - base_v;
    if (base_v >= len_v) begin
      seg_len_f = {SLW{1'b0}};
    end else if (rem_v >= 16'(PE_SIZE)) begin
      seg_len_f = SLW'(PE_SIZE);
    end else begin
      seg_len_f = rem_v[SLW-1:0];
    end
  endfunction

  assign accept_s   = (state_r == ST_IDLE) && i_start;
  assign seg_done_s = (state_r == ST_RUN) && i_seg_valid;
  assign seg_next_s = seg_base_r + 16'(PE_SIZE);
  // One extra bit so a query near 64K characters cannot wrap the compare.
  assign seg_end_s  = {1'b0, seg_base_r} + 17'(PE_SIZE);

  // Next-state and running-max selection.
  always_comb begin
    state_s = state_r;
    max_s   = max_r;
    case (state_r)
      ST_IDLE: begin
        if (i_start) begin
          max_s   = {VW{1'b0}};
          state_s = (i_s_len == 16'd0) ? ST_DONE : ST_LAUNCH;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LAUNCH: begin
        state_s = ST_RUN;
      end
      ST_RUN: begin
        if (i_seg_valid) begin
          max_s   = (i_seg_result > max_r) ? i_seg_result : max_r;
          state_s = (seg_end_s < {1'b0, s_len_r}) ? ST_LAUNCH : ST_DONE;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Control state and registered outputs, driven from the next state so
  // pulses line up with the cycle the state is entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      busy_r      <= 1'b0;
      seg_start_r <= 1'b0;
      valid_r     <= 1'b0;
      max_r       <= {VW{1'b0}};
      result_r    <= {VW{1'b0}};
      s_len_r     <= 16'd0;
      t_size_r    <= {TW{1'b0}};
      seg_base_r  <= 16'd0;
      seg_len_r   <= {SLW{1'b0}};
      seg_first_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      busy_r      <= (state_s != ST_IDLE);
      seg_start_r <= (state_s == ST_LAUNCH);
      valid_r     <= (state_s == ST_DONE);
      max_r       <= max_s;
      if (state_s == ST_DONE) begin
        result_r <= max_s;
      end
      if (accept_s) begin
        s_len_r     <= i_s_len;
        t_size_r    <= i_t_size;
        seg_base_r  <= 16'd0;
        seg_len_r   <= seg_len_f(i_s_len, 16'd0);
        seg_first_r <= (i_s_len != 16'd0);
      end else if (seg_done_s) begin
        seg_base_r  <= seg_next_s;
        seg_len_r   <= seg_len_f(s_len_r, seg_next_s);
        seg_first_r <= 1'b0;
      end
    end
  end

  // Reads past the T length and all reads of segment 0 yield 0/0; the
  // latter hides whatever a previous alignment left in the buffer.
  assign rd_en_s  = (state_r == ST_RUN) && i_bnd_rd;
  assign rd_clr_s = seg_first_r || (rd_ptr_r >= t_size_r);
  assign wr_en_s  = (state_r == ST_RUN) && i_bnd_wr && (wr_ptr_r < t_size_r);

  // Boundary pointers: rewound at each launch, advanced only in range.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_r <= {TW{1'b0}};
      wr_ptr_r <= {TW{1'b0}};
    end else if (state_r == ST_LAUNCH) begin
      rd_ptr_r <= {TW{1'b0}};
      wr_ptr_r <= {TW{1'b0}};
    end else begin
      if (rd_en_s && (rd_ptr_r < t_size_r)) begin
        rd_ptr_r <= rd_ptr_r + TW'(1'b1);
      end
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + TW'(1'b1);
      end
    end
  end

  sw_bound_buf #(
    .DEPTH (MAX_T),
    .AW    (AW),
    .DW    (2 * VW)
  ) u_bound_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en_s),
    .wr_addr (wr_ptr_r[AW-1:0]),
    .wr_data ({i_bnd_v, i_bnd_f}),
    .rd_en   (rd_en_s),
    .rd_clr  (rd_clr_s),
    .rd_addr (rd_ptr_r[AW-1:0]),
    .rd_data (rd_data_s)
  );

`ifdef SW_SEG_SCHED_PERF_EN
  logic [31:0] cycles_r;

  // Busy-cycle counter: cleared on accepted start, saturating, held when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycles_r <= 32'd0;
    end else if (accept_s) begin
      cycles_r <= 32'd0;
    end else if (busy_r && (cycles_r != 32'hFFFF_FFFF)) begin
      cycles_r <= cycles_r + 32'd1;
    end
  end

  assign o_cycles = cycles_r;
`endif

  assign o_busy      = busy_r;
  assign o_seg_start = seg_start_r;
  assign o_seg_base  = seg_base_r;
  assign o_seg_len   = seg_len_r;
  assign o_seg_first = seg_first_r;
  assign o_bnd_v     = rd_data_s[2*VW-1:VW];
  assign o_bnd_f     = rd_data_s[VW-1:0];
  assign o_result    = result_r;
  assign o_valid     = valid_r;

endmodule

// File: tb/tb_sw_segment_scheduler.sv
// Randomized scoreboard bench for sw_segment_scheduler (default parameters).
// The driver models each alignment from the segmentation and boundary rules,
// pushing expected launches, boundary reads and results into queues; a
// negedge monitor pops and compares whenever the DUT presents them.
module tb_sw_segment_scheduler;

  localparam int PE = 64;
  localparam int TW = 11;

  typedef struct packed {
    logic [15:0] base;
    logic [6:0]  len;
    logic        first;
  } seg_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_start;
  logic [15:0] i_s_len;
  logic [TW-1:0] i_t_size;
  logic        o_busy, o_seg_start, o_seg_first, o_valid;
  logic [15:0] o_seg_base;
  logic [6:0]  o_seg_len;
  logic        i_seg_valid;
  logic [15:0] i_seg_result;
  logic        i_bnd_wr, i_bnd_rd;
  logic [15:0] i_bnd_v, i_bnd_f;
  logic [15:0] o_bnd_v, o_bnd_f, o_result;
`ifdef SW_SEG_SCHED_PERF_EN
  logic [31:0] o_cycles;
`endif

  sw_segment_scheduler dut (
    .clk          (clk),
    .rst          (rst),
    .i_start      (i_start),
    .i_s_len      (i_s_len),
    .i_t_size     (i_t_size),
    .o_busy       (o_busy),
    .o_seg_start  (o_seg_start),
    .o_seg_base   (o_seg_base),
    .o_seg_len    (o_seg_len),
    .o_seg_first  (o_seg_first),
    .i_seg_valid  (i_seg_valid),
    .i_seg_result (i_seg_result),
    .i_bnd_wr     (i_bnd_wr),
    .i_bnd_v      (i_bnd_v),
    .i_bnd_f      (i_bnd_f),
    .i_bnd_rd     (i_bnd_rd),
    .o_bnd_v      (o_bnd_v),
    .o_bnd_f      (o_bnd_f),
    .o_result     (o_result),
`ifdef SW_SEG_SCHED_PERF_EN
    .o_cycles     (o_cycles),
`endif
    .o_valid      (o_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  seg_t        seg_q[$];
  logic [15:0] res_q[$];
  logic [31:0] bnd_q[$];
  int          forced_res[$];
  logic [31:0] mem_m [1024];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},  {31'd0, o_busy}, 32'd0);
    chk({tag, "_start"}, {31'd0, o_seg_start}, 32'd0);
    chk({tag, "_first"}, {31'd0, o_seg_first}, 32'd0);
    chk({tag, "_valid"}, {31'd0, o_valid}, 32'd0);
    chk({tag, "_base"},  {16'd0, o_seg_base}, 32'd0);
    chk({tag, "_len"},   {25'd0, o_seg_len}, 32'd0);
    chk({tag, "_bnd"},   {o_bnd_v, o_bnd_f}, 32'd0);
    chk({tag, "_res"},   {16'd0, o_result}, 32'd0);
  endtask

  // Monitor: compares whatever the DUT presents against the queues.
  initial begin : monitor
    bit   rd_pend;
    seg_t s;
    logic [31:0] b;
    rd_pend = 1'b0;
    forever begin
      @(negedge clk);
      if (rd_pend) begin
        if (bnd_q.size() == 0) begin
          chk("bnd_unexpected", 32'd1, 32'd0);
        end else begin
          b = bnd_q.pop_front();
          chk("bnd_v", {16'd0, o_bnd_v}, {16'd0, b[31:16]});
          chk("bnd_f", {16'd0, o_bnd_f}, {16'd0, b[15:0]});
        end
      end
      rd_pend = i_bnd_rd && o_busy && !rst;
      if (o_seg_start) begin
        if (seg_q.size() == 0) begin
          chk("seg_unexpected", 32'd1, 32'd0);
        end else begin
          s = seg_q.pop_front();
          chk("seg_base",  {16'd0, o_seg_base}, {16'd0, s.base});
          chk("seg_len",   {25'd0, o_seg_len}, {25'd0, s.len});
          chk("seg_first", {31'd0, o_seg_first}, {31'd0, s.first});
        end
      end
      if (o_valid) begin
        if (res_q.size() == 0) begin
          chk("valid_unexpected", 32'd1, 32'd0);
        end else begin
          chk("result", {16'd0, o_result}, {16'd0, res_q.pop_front()});
        end
      end
    end
  end

  // One alignment. mode 0: random boundary traffic; mode 1: lockstep
  // rd+wr with V = pass*32+j+1, F = V+8. abort_seg >= 0 resets mid-pass.
  task automatic run_align(input int s_len, input int t, input int mode, input int abort_seg);
    int nseg, rmax, nrd, nwr, ri, wi, wj, cn, c0, len;
    int res_a[$];
    bit rd, wr;
    seg_t s;
    logic [31:0] e;
    logic [15:0] wv, wf;
    nseg = (s_len + PE - 1) / PE;
    rmax = 0;
    for (int k = 0; k < nseg; k++) begin
      len = s_len - k * PE;
      if (len > PE) len = PE;
      s.base  = 16'(k * PE);
      s.len   = 7'(len);
      s.first = (k == 0);
      seg_q.push_back(s);
      if (forced_res.size() > 0) res_a.push_back(forced_res.pop_front());
      else if ($urandom_range(0, 7) == 0) res_a.push_back(65535);
      else res_a.push_back(int'($urandom_range(0, 65535)));
      if (res_a[k] > rmax) rmax = res_a[k];
    end
    res_q.push_back(16'(rmax));
    i_s_len  = 16'(s_len);
    i_t_size = TW'(t);
    i_start  = 1'b1;
    tick();
    i_start = 1'b0;
    c0 = cyc;
    chk("start_busy", {31'd0, o_busy}, 32'd1);
    if (nseg == 0) begin
      chk("empty_valid", {31'd0, o_valid}, 32'd1);
      chk("empty_nolaunch", {31'd0, o_seg_start}, 32'd0);
    end else begin
      chk("start_launch", {31'd0, o_seg_start}, 32'd1);
    end
    for (int k = 0; k < nseg; k++) begin
      // LAUNCH cycle: a pass-done here must be ignored.
      if (mode == 0 && $urandom_range(0, 1) == 1) begin
        i_seg_valid  = 1'b1;
        i_seg_result = 16'hFFFF;
      end
      tick();
      i_seg_valid = 1'b0;
      nrd = t + ((mode == 1) ? 1 : int'($urandom_range(0, 2)));
      nwr = (mode == 1) ? nrd : t + int'($urandom_range(0, 2));
      ri = 0; wi = 0; wj = 0; cn = 0;
      while (nrd > 0 || nwr > 0) begin
        if (k == abort_seg && cn == t / 2) begin
          rst = 1'b1;
          tick();
          chk_all_zero("abort");
          rst = 1'b0;
          seg_q.delete();
          res_q.delete();
          bnd_q.delete();
          tick();
          return;
        end
        rd = (nrd > 0) && (mode == 1 || $urandom_range(0, 1) == 1);
        wr = (nwr > 0) && (mode == 1 || $urandom_range(0, 1) == 1);
        if (mode == 0 && k == 0 && cn == 0) begin
          i_start = 1'b1;
          i_s_len = 16'd7;
        end
        wv = (mode == 1) ? 16'(k * 32 + wj + 1) : 16'($urandom_range(0, 65535));
        wf = (mode == 1) ? wv + 16'd8 : 16'($urandom_range(0, 65535));
        if (rd) begin
          e = (k == 0 || ri >= t) ? 32'd0 : mem_m[ri];
          bnd_q.push_back(e);
          if (ri < t) ri++;
          nrd--;
        end
        if (wr) begin
          if (wi < t) begin
            mem_m[wi] = {wv, wf};
            wi++;
          end
          wj++;
          nwr--;
        end
        i_bnd_rd = rd;
        i_bnd_wr = wr;
        i_bnd_v  = wv;
        i_bnd_f  = wf;
        tick();
        i_bnd_rd = 1'b0;
        i_bnd_wr = 1'b0;
        i_start  = 1'b0;
        cn++;
      end
      chk("run_busy", {31'd0, o_busy}, 32'd1);
      i_seg_valid  = 1'b1;
      i_seg_result = 16'(res_a[k]);
      tick();
      i_seg_valid = 1'b0;
      if (k < nseg - 1) begin
        chk("next_launch", {31'd0, o_seg_start}, 32'd1);
      end else begin
        chk("final_valid", {31'd0, o_valid}, 32'd1);
        chk("final_nolaunch", {31'd0, o_seg_start}, 32'd0);
      end
    end
    tick();
    chk("idle_busy", {31'd0, o_busy}, 32'd0);
    chk("idle_valid", {31'd0, o_valid}, 32'd0);
    chk("result_hold", {16'd0, o_result}, 32'(rmax));
`ifdef SW_SEG_SCHED_PERF_EN
    chk("cycles", o_cycles, 32'(cyc - c0));
`endif
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : driver
    logic [31:0] held;
    for (int i = 0; i < 1024; i++) mem_m[i] = 32'd0;
    rst = 1'b1; i_start = 1'b0; i_s_len = 16'd0; i_t_size = '0;
    i_seg_valid = 1'b0; i_seg_result = 16'd0;
    i_bnd_wr = 1'b0; i_bnd_rd = 1'b0; i_bnd_v = 16'd0; i_bnd_f = 16'd0;
    repeat (3) tick();
    chk_all_zero("reset");
    rst = 1'b0;
    tick();

    run_align(0, 4, 0, -1);
    forced_res.push_back(10);
    forced_res.push_back(37);
    forced_res.push_back(22);
    run_align(150, 5, 0, -1);
    run_align(100, 8, 1, -1);

    // Pass-done and boundary strobes while idle must do nothing.
    held = {o_bnd_v, o_bnd_f};
    i_seg_valid = 1'b1; i_seg_result = 16'hFFFF;
    i_bnd_wr = 1'b1; i_bnd_rd = 1'b1;
    tick();
    i_seg_valid = 1'b0; i_bnd_wr = 1'b0; i_bnd_rd = 1'b0;
    tick();
    chk("idle_ign_busy", {31'd0, o_busy}, 32'd0);
    chk("idle_ign_bnd", {o_bnd_v, o_bnd_f}, held);

    run_align(200, 6, 0, 2);
    run_align(200, 6, 0, -1);
    run_align(64, 3, 0, -1);
    run_align(128, 10, 0, -1);
    for (int n = 0; n < 6; n++) begin
      run_align(int'($urandom_range(1, 400)), int'($urandom_range(1, 16)), 0, -1);
    end

    repeat (3) tick();
    chk("seg_q_empty", 32'(seg_q.size()), 32'd0);
    chk("res_q_empty", 32'(res_q.size()), 32'd0);
    chk("bnd_q_empty", 32'(bnd_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
